// File: rtl/hxdp_mem_loader.sv
// -----------------------------------------------------------------------------
// hxdp_mem_loader
//
// Register-interface initiator that programs Sephirot instruction and map
// memories. One memory line is accepted per valid/ready beat and turned into a
// sequence of word writes followed by a commit write to the memory register
// block. With VERIFY=1 the words are read back and compared after the commit.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   s_valid/s_ready      line beat handshake
//   s_data[255:0]        line data, word i = s_data[32i+31:32i]
//   s_line[7:0]          target line index
//   s_is_map             1 = map line (4 words, region 2), 0 = instr (8 words, region 1)
//   reg_wr_*             register write master (addr/data/strb/en, wait/ack from slave)
//   reg_rd_*             register read master (addr/en, data/wait/ack from slave)
//   busy                 high whenever the FSM is not idle
//   line_count[15:0]     lines committed successfully (wraps)
//   err_timeout          sticky: a request was not acknowledged in time
//   err_mismatch         sticky: a readback word differed from the written word
// -----------------------------------------------------------------------------
module hxdp_mem_loader #(
   parameter int REG_ADDR_WIDTH = 20,
   parameter int REG_DATA_WIDTH = 32,
   parameter int REG_STRB_WIDTH = 4,
   parameter int RB_BASE_ADDR   = 0,
   parameter bit VERIFY         = 1'b1,
   parameter int TIMEOUT        = 1023
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [255:0]              s_data,
   input  logic [7:0]                s_line,
   input  logic                      s_is_map,
   output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
   output logic [REG_DATA_WIDTH-1:0] reg_wr_data,
   output logic [REG_STRB_WIDTH-1:0] reg_wr_strb,
   output logic                      reg_wr_en,
   input  logic                      reg_wr_wait,
   input  logic                      reg_wr_ack,
   output logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
   output logic                      reg_rd_en,
   input  logic [REG_DATA_WIDTH-1:0] reg_rd_data,
   input  logic                      reg_rd_wait,
   input  logic                      reg_rd_ack,
   output logic                      busy,
   output logic [15:0]               line_count,
   output logic                      err_timeout,
   output logic                      err_mismatch
);

   typedef enum logic [2:0] {
      IDLE,
      WR_WORD,
      WR_GAP,
      WR_COMMIT,
      RD_WORD,
      RD_GAP
   } state_t;

   // Last count value before the request is abandoned: with the counter
   // starting at 0 the request stays up for exactly TIMEOUT counting cycles.
   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

   state_t         state;
   logic [255:0]   line_data;
   logic [7:0]     line_idx;
   logic           line_map;
   logic [3:0]     n_words;
   logic [3:0]     idx;
   logic [9:0]     tcnt;
   logic           line_miss;

   function automatic logic [REG_ADDR_WIDTH-1:0] word_addr(input logic map,
                                                           input logic [3:0] w);
      logic [3:0] region;
      region = map ? 4'd2 : 4'd1;
      return REG_ADDR_WIDTH'(RB_BASE_ADDR) + REG_ADDR_WIDTH'({region, 16'h0000})
             + REG_ADDR_WIDTH'({w, 2'b00});
   endfunction

   function automatic logic [REG_ADDR_WIDTH-1:0] commit_addr(input logic map,
                                                             input logic [7:0] line);
      logic [3:0] region;
      region = map ? 4'd2 : 4'd1;
      return REG_ADDR_WIDTH'(RB_BASE_ADDR) + REG_ADDR_WIDTH'({region, 16'h0000})
             + REG_ADDR_WIDTH'({line, 8'hFC});
   endfunction

   function automatic logic [31:0] word_of(input logic [255:0] d, input logic [3:0] w);
      return d[{w[2:0], 5'd0} +: 32];
   endfunction

   assign reg_wr_strb = '1;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         s_ready      <= 1'b1;
         reg_wr_en    <= 1'b0;
         reg_rd_en    <= 1'b0;
         reg_wr_addr  <= '0;
         reg_wr_data  <= '0;
         reg_rd_addr  <= '0;
         line_count   <= '0;
         err_timeout  <= 1'b0;
         err_mismatch <= 1'b0;
         idx          <= '0;
         n_words      <= '0;
         tcnt         <= '0;
         line_miss    <= 1'b0;
         line_idx     <= '0;
         line_map     <= 1'b0;
         line_data    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_valid && s_ready) begin
                  line_data   <= s_data;
                  line_idx    <= s_line;
                  line_map    <= s_is_map;
                  n_words     <= s_is_map ? 4'd4 : 4'd8;
                  idx         <= '0;
                  tcnt        <= '0;
                  line_miss   <= 1'b0;
                  s_ready     <= 1'b0;
                  reg_wr_addr <= word_addr(s_is_map, 4'd0);
                  reg_wr_data <= s_data[31:0];
                  reg_wr_en   <= 1'b1;
                  state       <= WR_WORD;
               end
            end

            WR_WORD, WR_COMMIT: begin
               // Ack is checked first so an ack on the expiry cycle still wins.
               if (reg_wr_ack) begin
                  reg_wr_en <= 1'b0;
                  if (state == WR_WORD) begin
                     idx   <= idx + 4'd1;
                     state <= WR_GAP;
                  end else if (VERIFY) begin
                     idx   <= '0;
                     state <= RD_GAP;
                  end else begin
                     line_count <= line_count + 16'd1;
                     s_ready    <= 1'b1;
                     state      <= IDLE;
                  end
               end else if (!reg_wr_wait) begin
                  if (tcnt == TMO_LAST) begin
                     reg_wr_en   <= 1'b0;
                     err_timeout <= 1'b1;
                     s_ready     <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     tcnt <= tcnt + 10'd1;
                  end
               end
            end

            // One idle cycle between requests; the slave holds ack for one cycle.
            WR_GAP: begin
               tcnt      <= '0;
               reg_wr_en <= 1'b1;
               if (idx == n_words) begin
                  reg_wr_addr <= commit_addr(line_map, line_idx);
                  reg_wr_data <= '0;
                  state       <= WR_COMMIT;
               end else begin
                  reg_wr_addr <= word_addr(line_map, idx);
                  reg_wr_data <= word_of(line_data, idx);
                  state       <= WR_WORD;
               end
            end

            RD_GAP: begin
               if (idx == n_words) begin
                  if (!line_miss) line_count <= line_count + 16'd1;
                  s_ready <= 1'b1;
                  state   <= IDLE;
               end else begin
                  tcnt        <= '0;
                  reg_rd_addr <= word_addr(line_map, idx);
                  reg_rd_en   <= 1'b1;
                  state       <= RD_WORD;
               end
            end

            RD_WORD: begin
               if (reg_rd_ack) begin
                  reg_rd_en <= 1'b0;
                  // Keep reading the rest of the line so the whole line is checked.
                  if (reg_rd_data != word_of(line_data, idx)) begin
                     line_miss    <= 1'b1;
                     err_mismatch <= 1'b1;
                  end
                  idx   <= idx + 4'd1;
                  state <= RD_GAP;
               end else if (!reg_rd_wait) begin
                  if (tcnt == TMO_LAST) begin
                     reg_rd_en   <= 1'b0;
                     err_timeout <= 1'b1;
                     s_ready     <= 1'b1;
                     state       <= IDLE;
                  end else begin
                     tcnt <= tcnt + 10'd1;
                  end
               end
            end

            default: begin
               reg_wr_en <= 1'b0;
               reg_rd_en <= 1'b0;
               s_ready   <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hxdp_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_hxdp_mem_loader
//
// Two loaders share the line stimulus: index 0 is write-only (VERIFY=0),
// index 1 reads back and compares (VERIFY=1). Each has its own register
// slave model that acks one cycle after a request, logs writes, serves
// readback from the written words and can stall, drop or corrupt responses.
// -----------------------------------------------------------------------------
module tb_hxdp_mem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         s_valid [2];
   logic [255:0] s_data;
   logic [7:0]   s_line;
   logic         s_is_map;
   logic         s_ready [2];
   logic [19:0]  wr_addr [2];
   logic [31:0]  wr_data [2];
   logic [3:0]   wr_strb [2];
   logic         wr_en   [2];
   logic         wr_wait [2];
   logic         wr_ack  [2];
   logic [19:0]  rd_addr [2];
   logic         rd_en   [2];
   logic [31:0]  rd_data [2];
   logic         rd_wait [2];
   logic         rd_ack  [2];
   logic         busy    [2];
   logic [15:0]  line_count [2];
   logic         err_timeout  [2];
   logic         err_mismatch [2];

   // slave model state and controls
   logic [19:0]  wlog_a [2][64];
   logic [31:0]  wlog_d [2][64];
   logic [5:0]   wcnt [2] = '{6'd0, 6'd0};
   logic [5:0]   rcnt [2] = '{6'd0, 6'd0};
   logic [31:0]  mem  [2][8];
   logic         drop_en [2];
   logic [19:0]  drop_addr [2];
   logic         corrupt_en [2];
   logic [2:0]   corrupt_idx [2];
   int           overlap = 0;

   int n_vec  = 0;
   int n_miss = 0;

   hxdp_mem_loader #(.REG_ADDR_WIDTH(20), .REG_DATA_WIDTH(32), .REG_STRB_WIDTH(4),
                     .RB_BASE_ADDR(0), .VERIFY(1'b0), .TIMEOUT(1023)) u_wo (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data), .s_line(s_line),
      .s_is_map(s_is_map),
      .reg_wr_addr(wr_addr[0]), .reg_wr_data(wr_data[0]), .reg_wr_strb(wr_strb[0]),
      .reg_wr_en(wr_en[0]), .reg_wr_wait(wr_wait[0]), .reg_wr_ack(wr_ack[0]),
      .reg_rd_addr(rd_addr[0]), .reg_rd_en(rd_en[0]), .reg_rd_data(rd_data[0]),
      .reg_rd_wait(rd_wait[0]), .reg_rd_ack(rd_ack[0]),
      .busy(busy[0]), .line_count(line_count[0]),
      .err_timeout(err_timeout[0]), .err_mismatch(err_mismatch[0]));

   hxdp_mem_loader #(.REG_ADDR_WIDTH(20), .REG_DATA_WIDTH(32), .REG_STRB_WIDTH(4),
                     .RB_BASE_ADDR(0), .VERIFY(1'b1), .TIMEOUT(1023)) u_vf (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data), .s_line(s_line),
      .s_is_map(s_is_map),
      .reg_wr_addr(wr_addr[1]), .reg_wr_data(wr_data[1]), .reg_wr_strb(wr_strb[1]),
      .reg_wr_en(wr_en[1]), .reg_wr_wait(wr_wait[1]), .reg_wr_ack(wr_ack[1]),
      .reg_rd_addr(rd_addr[1]), .reg_rd_en(rd_en[1]), .reg_rd_data(rd_data[1]),
      .reg_rd_wait(rd_wait[1]), .reg_rd_ack(rd_ack[1]),
      .busy(busy[1]), .line_count(line_count[1]),
      .err_timeout(err_timeout[1]), .err_mismatch(err_mismatch[1]));

   // Register slaves: ack registered one cycle after a request is seen,
   // requests ignored while the ack is high.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         wr_ack[k] <= 1'b0;
         rd_ack[k] <= 1'b0;
         if (wr_en[k] && !wr_ack[k] && !wr_wait[k] &&
             !(drop_en[k] && wr_addr[k] == drop_addr[k])) begin
            wr_ack[k] <= 1'b1;
            wlog_a[k][wcnt[k]] <= wr_addr[k];
            wlog_d[k][wcnt[k]] <= wr_data[k];
            wcnt[k] <= wcnt[k] + 6'd1;
            if (wr_addr[k][7:0] != 8'hFC) mem[k][wr_addr[k][4:2]] <= wr_data[k];
         end
         if (rd_en[k] && !rd_ack[k] && !rd_wait[k]) begin
            rd_ack[k]  <= 1'b1;
            rd_data[k] <= mem[k][rd_addr[k][4:2]] ^
                          ((corrupt_en[k] && rd_addr[k][4:2] == corrupt_idx[k]) ? 32'h100 : 32'h0);
            rcnt[k] <= rcnt[k] + 6'd1;
         end
         if (wr_en[k] && rd_en[k]) overlap <= overlap + 1;
      end
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_line(input int k, input logic [7:0] line, input logic map);
      s_line     = line;
      s_is_map   = map;
      s_valid[k] = 1'b1;
      @(negedge clk);
      s_valid[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k, input int budget, output int cyc);
      cyc = 0;
      while (busy[k] && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int         cyc;
      logic [5:0] base;
      logic [5:0] rbase;
      logic       found;

      rst_n    = 1'b0;
      s_data   = '0;
      s_line   = '0;
      s_is_map = 1'b0;
      for (int k = 0; k < 2; k++) begin
         s_valid[k]     = 1'b0;
         wr_wait[k]     = 1'b0;
         rd_wait[k]     = 1'b0;
         drop_en[k]     = 1'b0;
         drop_addr[k]   = '0;
         corrupt_en[k]  = 1'b0;
         corrupt_idx[k] = '0;
      end
      repeat (3) @(negedge clk);

      // reset state
      check_vec("rst_s_ready",   32'(s_ready[0]), 32'd1);
      check_vec("rst_wr_en",     32'(wr_en[0]), 32'd0);
      check_vec("rst_rd_en",     32'(rd_en[1]), 32'd0);
      check_vec("rst_busy",      32'(busy[0]), 32'd0);
      check_vec("rst_count",     32'(line_count[0]), 32'd0);
      check_vec("rst_err_tmo",   32'(err_timeout[0]), 32'd0);
      check_vec("rst_err_mis",   32'(err_mismatch[1]), 32'd0);
      check_vec("rst_wr_addr",   32'(wr_addr[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // instr line 0x05, words 0x11..0x88, write only
      s_data = {32'h88, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
      base = wcnt[0];
      send_line(0, 8'h05, 1'b0);
      check_vec("t1_ready_low", 32'(s_ready[0]), 32'd0);
      check_vec("t1_busy",      32'(busy[0]), 32'd1);
      check_vec("t1_strb",      32'(wr_strb[0]), 32'hF);
      wait_idle(0, 100, cyc);
      check_vec("t1_idle",      32'(busy[0]), 32'd0);
      check_vec("t1_nwrites",   32'(6'(wcnt[0] - base)), 32'd9);
      for (int i = 0; i < 8; i++) begin
         check_vec("t1_addr", 32'(wlog_a[0][base + 6'(i)]), 32'h10000 + 32'(4 * i));
         check_vec("t1_data", wlog_d[0][base + 6'(i)], 32'h11 * 32'(i + 1));
      end
      check_vec("t1_commit_a",  32'(wlog_a[0][base + 6'd8]), 32'h105FC);
      check_vec("t1_commit_d",  wlog_d[0][base + 6'd8], 32'h0);
      check_vec("t1_count",     32'(line_count[0]), 32'd1);
      check_vec("t1_ready",     32'(s_ready[0]), 32'd1);

      // map line 0xA3: only words 0..3, region 2
      s_data = {32'hDEAD0007, 32'hDEAD0006, 32'hDEAD0005, 32'hDEAD0004,
                32'hD4, 32'hC3, 32'hB2, 32'hA1};
      base = wcnt[0];
      send_line(0, 8'hA3, 1'b1);
      wait_idle(0, 100, cyc);
      check_vec("t2_idle",      32'(busy[0]), 32'd0);
      check_vec("t2_nwrites",   32'(6'(wcnt[0] - base)), 32'd5);
      check_vec("t2_a0",        32'(wlog_a[0][base]), 32'h20000);
      check_vec("t2_d0",        wlog_d[0][base], 32'hA1);
      check_vec("t2_a3",        32'(wlog_a[0][base + 6'd3]), 32'h2000C);
      check_vec("t2_d3",        wlog_d[0][base + 6'd3], 32'hD4);
      check_vec("t2_commit_a",  32'(wlog_a[0][base + 6'd4]), 32'h2A3FC);
      check_vec("t2_count",     32'(line_count[0]), 32'd2);

      // slave stalls the first write for 2000 cycles: no timeout
      s_data = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
      base = wcnt[0];
      wr_wait[0] = 1'b1;
      send_line(0, 8'h01, 1'b0);
      repeat (2000) @(negedge clk);
      check_vec("t4_held_en",   32'(wr_en[0]), 32'd1);
      check_vec("t4_held_addr", 32'(wr_addr[0]), 32'h10000);
      wr_wait[0] = 1'b0;
      wait_idle(0, 100, cyc);
      check_vec("t4_idle",      32'(busy[0]), 32'd0);
      check_vec("t4_err_tmo",   32'(err_timeout[0]), 32'd0);
      check_vec("t4_nwrites",   32'(6'(wcnt[0] - base)), 32'd9);
      check_vec("t4_commit_a",  32'(wlog_a[0][base + 6'd8]), 32'h101FC);
      check_vec("t4_count",     32'(line_count[0]), 32'd3);

      // word 3 never acknowledged: timeout, no commit, no count
      base = wcnt[0];
      drop_en[0]   = 1'b1;
      drop_addr[0] = 20'h1000C;
      send_line(0, 8'h02, 1'b0);
      wait_idle(0, 1200, cyc);
      drop_en[0] = 1'b0;
      check_vec("t5_idle",      32'(busy[0]), 32'd0);
      check_vec("t5_duration",  32'(cyc >= 1023 && cyc <= 1045), 32'd1);
      check_vec("t5_err_tmo",   32'(err_timeout[0]), 32'd1);
      check_vec("t5_wr_en",     32'(wr_en[0]), 32'd0);
      check_vec("t5_nwrites",   32'(6'(wcnt[0] - base)), 32'd3);
      check_vec("t5_last_a",    32'(wlog_a[0][base + 6'd2]), 32'h10008);
      check_vec("t5_count",     32'(line_count[0]), 32'd3);
      check_vec("t5_ready",     32'(s_ready[0]), 32'd1);

      // verify loader, clean readback
      s_data = {32'hF8, 32'hE7, 32'hD6, 32'hC5, 32'hB4, 32'hA3, 32'h92, 32'h81};
      base  = wcnt[1];
      rbase = rcnt[1];
      send_line(1, 8'h07, 1'b0);
      wait_idle(1, 200, cyc);
      check_vec("t3a_idle",     32'(busy[1]), 32'd0);
      check_vec("t3a_nwrites",  32'(6'(wcnt[1] - base)), 32'd9);
      check_vec("t3a_commit_a", 32'(wlog_a[1][base + 6'd8]), 32'h107FC);
      check_vec("t3a_nreads",   32'(6'(rcnt[1] - rbase)), 32'd8);
      check_vec("t3a_err_mis",  32'(err_mismatch[1]), 32'd0);
      check_vec("t3a_count",    32'(line_count[1]), 32'd1);

      // verify loader, word 2 corrupted on readback
      rbase = rcnt[1];
      corrupt_en[1]  = 1'b1;
      corrupt_idx[1] = 3'd2;
      send_line(1, 8'h08, 1'b0);
      wait_idle(1, 200, cyc);
      corrupt_en[1] = 1'b0;
      check_vec("t3b_idle",     32'(busy[1]), 32'd0);
      check_vec("t3b_nreads",   32'(6'(rcnt[1] - rbase)), 32'd8);
      check_vec("t3b_err_mis",  32'(err_mismatch[1]), 32'd1);
      check_vec("t3b_count",    32'(line_count[1]), 32'd1);
      check_vec("t3b_ready",    32'(s_ready[1]), 32'd1);
      check_vec("rw_overlap",   32'(overlap), 32'd0);

      // reset while word 4 is being written
      send_line(0, 8'h03, 1'b0);
      found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
         if (wr_en[0] && wr_addr[0] == 20'h10010) found = 1'b1;
         else @(negedge clk);
      end
      check_vec("t6_word4_seen", 32'(found), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_vec("t6_wr_en",     32'(wr_en[0]), 32'd0);
      check_vec("t6_busy",      32'(busy[0]), 32'd0);
      check_vec("t6_ready",     32'(s_ready[0]), 32'd1);
      check_vec("t6_count",     32'(line_count[0]), 32'd0);
      check_vec("t6_err_tmo",   32'(err_timeout[0]), 32'd0);
      check_vec("t6_err_mis",   32'(err_mismatch[1]), 32'd0);
      check_vec("t6_count_vf",  32'(line_count[1]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
